// File: rtl/bocks_mem_pkg.sv
// Shared types and constants for the bocks SDRAM port arbiter and its download word packer.
package bocks_mem_pkg;

    localparam int DEF_ADDR_W = 24;

    localparam logic [1:0] BE_LO  = 2'b01;
    localparam logic [1:0] BE_HI  = 2'b10;
    localparam logic [1:0] BE_ALL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VID_CMD,
        ST_VID_WAIT,
        ST_DL_CMD
    } arb_state_t;

    function automatic logic [1:0] lane_be(input logic lane);
        return lane ? BE_HI : BE_LO;
    endfunction

    function automatic logic [15:0] lane_data(input logic lane, input logic [7:0] b);
        return lane ? {b, 8'h00} : {8'h00, b};
    endfunction

endpackage

// File: rtl/ioctl_word_packer.sv
// Packs ioctl download bytes into 16-bit words with byte enables, parks a byte that
// belongs to a new word while the old one flushes, and drives ioctl_wait.
module ioctl_word_packer
    import bocks_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_ram,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W:0]   ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              flush_ack,
    output logic              word_ready,
    output logic [ADDR_W-1:0] word_addr,
    output logic [15:0]       word_data,
    output logic [1:0]        word_be
);

    logic [ADDR_W-1:0] buf_addr;
    logic [15:0]       buf_data;
    logic [1:0]        buf_be;
    logic              buf_ready;
    logic              hold_valid;
    logic [ADDR_W:0]   hold_addr;
    logic [7:0]        hold_byte;

    logic              wr_ok;
    logic              wr_lane;
    logic [ADDR_W-1:0] wr_word;
    logic [1:0]        merged_be;

    assign wr_ok     = ioctl_download && ioctl_wr && !buf_ready;
    assign wr_lane   = ioctl_addr[0];
    assign wr_word   = ioctl_addr[ADDR_W:1];
    assign merged_be = buf_be | lane_be(wr_lane);

    // A partial word with the session closed is flushed as-is; this also covers a
    // hold byte reloaded after the download has already ended.
    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            // NOTE: the data registers are cleared too, so no stale byte can ride along in a later flush.
            buf_addr   <= '0;
            buf_data   <= '0;
            buf_be     <= '0;
            buf_ready  <= 1'b0;
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_byte  <= '0;
        end else if (flush_ack) begin
            buf_ready  <= 1'b0;
            hold_valid <= 1'b0;
            if (hold_valid) begin
                buf_addr <= hold_addr[ADDR_W:1];
                buf_data <= lane_data(hold_addr[0], hold_byte);
                buf_be   <= lane_be(hold_addr[0]);
            end else begin
                buf_be <= '0;
            end
        end else if (wr_ok) begin
            if (buf_be == '0) begin
                buf_addr <= wr_word;
                buf_data <= lane_data(wr_lane, ioctl_dout);
                buf_be   <= lane_be(wr_lane);
            end else if (wr_word == buf_addr) begin
                if (wr_lane) buf_data[15:8] <= ioctl_dout;
                else         buf_data[7:0]  <= ioctl_dout;
                buf_be    <= merged_be;
                buf_ready <= (merged_be == BE_ALL);
            end else begin
                buf_ready  <= 1'b1;
                hold_valid <= 1'b1;
                hold_addr  <= ioctl_addr;
                hold_byte  <= ioctl_dout;
            end
        end else if (!ioctl_download && buf_be != '0) begin
            buf_ready <= 1'b1;
        end
    end

    assign ioctl_wait = buf_ready;
    assign word_ready = buf_ready;
    assign word_addr  = buf_addr;
    assign word_data  = buf_data;
    assign word_be    = buf_be;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM command port between the ioctl download writer and the video reader.
// Define BOCKS_ARB_STARVE_EN to bound consecutive video grants while a download word waits.
module sdram_port_arbiter
    import bocks_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_ram,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W:0]   ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_valid,
    output logic [15:0]       vid_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata
);

    arb_state_t        state_q, state_d;
    logic              word_ready;
    logic [ADDR_W-1:0] word_addr;
    logic [15:0]       word_data;
    logic [1:0]        word_be;
    logic              flush_ack;
    logic              force_dl;
    logic              rd_done;

    assign flush_ack = (state_q == ST_DL_CMD) && mem_ack;
    assign rd_done   = (state_q == ST_VID_WAIT) && mem_rvalid;

    ioctl_word_packer #(.ADDR_W(ADDR_W)) u_packer (
        .clk_ram        (clk_ram),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .flush_ack      (flush_ack),
        .word_ready     (word_ready),
        .word_addr      (word_addr),
        .word_data      (word_data),
        .word_be        (word_be)
    );

`ifdef BOCKS_ARB_STARVE_EN
    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign force_dl = word_ready && (starve_cnt == CNT_MAX);

    // Counts only video grants that bypass a waiting download word.
    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!word_ready || (state_q == ST_IDLE && state_d == ST_DL_CMD)) begin
            starve_cnt <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_VID_CMD) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign force_dl            = 1'b0;
`endif

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        vid_ack   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (force_dl)        state_d = ST_DL_CMD;
                else if (vid_req)    state_d = ST_VID_CMD;
                else if (word_ready) state_d = ST_DL_CMD;
            end
            ST_VID_CMD: begin
                mem_req  = 1'b1;
                mem_addr = vid_addr;
                vid_ack  = mem_ack;
                if (mem_ack) state_d = ST_VID_WAIT;
            end
            ST_VID_WAIT: begin
                if (mem_rvalid) state_d = ST_IDLE;
            end
            ST_DL_CMD: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = word_data;
                mem_be    = word_be;
                if (mem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            vid_valid <= 1'b0;
            vid_data  <= '0;
        end else begin
            vid_valid <= rd_done;
            if (rd_done) vid_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small SDRAM controller model
// (ack 2 cycles after mem_req, read data 5 cycles after mem_req).
module tb_sdram_port_arbiter;

    logic        clk_ram;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        vid_req;
    logic [23:0] vid_addr;
    logic        vid_ack;
    logic        vid_valid;
    logic [15:0] vid_data;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    logic        log_we[$];
    logic [23:0] log_addr[$];
    logic [15:0] log_wdata[$];
    logic [1:0]  log_be[$];

    sdram_port_arbiter #(.ADDR_W(24), .STARVE_LIMIT(4)) dut (
        .clk_ram        (clk_ram),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .vid_req        (vid_req),
        .vid_addr       (vid_addr),
        .vid_ack        (vid_ack),
        .vid_valid      (vid_valid),
        .vid_data       (vid_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_ack        (mem_ack),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    initial clk_ram = 1'b0;
    always #5 clk_ram = ~clk_ram;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_ram);
        #2;
    endtask

    task automatic ioctl_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        tick();
    endtask

    // Leaves the caller at the falling edge of the mem_ack cycle.
    task automatic wait_ack(input string tag);
        int n = 0;
        do begin
            @(negedge clk_ram);
            n++;
        end while (!mem_ack && n < 64);
        check({tag, "_ack_seen"}, {31'b0, mem_ack}, 32'd1);
    endtask

    // SDRAM controller model, reset by the same reset_n as the arbiter.
    initial begin : ctrl_model
        bit busy;
        int age;
        int rd_cnt;
        busy = 0; age = 0; rd_cnt = 0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
        forever begin
            @(posedge clk_ram or negedge reset_n);
            if (!reset_n) begin
                mem_ack = 1'b0; mem_rvalid = 1'b0; busy = 0; rd_cnt = 0;
            end else begin
                #1;
                mem_ack    = 1'b0;
                mem_rvalid = 1'b0;
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = 16'hBEEF;
                    end
                end
                if (mem_req) begin
                    if (!busy) begin busy = 1; age = 0; end
                    else age++;
                    if (age == 2) begin
                        mem_ack = 1'b1;
                        busy    = 0;
                        log_we.push_back(mem_we);
                        log_addr.push_back(mem_addr);
                        log_wdata.push_back(mem_wdata);
                        log_be.push_back(mem_be);
                        if (!mem_we) rd_cnt = 3;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n, base, s, nw, spurious;
        logic [4:0] pat;
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
        ioctl_dout = '0; vid_req = 1'b0; vid_addr = '0;
        repeat (2) @(posedge clk_ram);
        @(negedge clk_ram);
        check("rst_outputs_a", {ioctl_wait, vid_ack, vid_valid, mem_req, mem_we, mem_be}, 32'd0);
        check("rst_outputs_b", {vid_data, mem_wdata}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Aligned byte pair
        ioctl_download = 1'b1;
        ioctl_byte(25'h000, 8'h34);
        ioctl_addr = 25'h001; ioctl_dout = 8'h12; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        @(negedge clk_ram);
        check("pair_wait_high", ioctl_wait, 32'd1);
        wait_ack("pair");
        check("pair_we", mem_we, 32'd1);
        check("pair_addr", mem_addr, 32'h0);
        check("pair_wdata", mem_wdata, 32'h1234);
        check("pair_be", mem_be, 32'h3);
        check("pair_wait_at_ack", ioctl_wait, 32'd1);
        @(negedge clk_ram);
        check("pair_wait_low", ioctl_wait, 32'd0);
        check("pair_req_low", mem_req, 32'd0);

        // Odd trailing byte flushed by the end of the session
        tick();
        ioctl_byte(25'h005, 8'hAB);
        ioctl_download = 1'b0;
        wait_ack("odd");
        check("odd_addr", mem_addr, 32'h2);
        check("odd_be", mem_be, 32'h2);
        check("odd_wdata_hi", mem_wdata[15:8], 32'hAB);

        // Strobe with download low is ignored
        tick();
        s = log_we.size();
        ioctl_byte(25'h040, 8'h99);
        repeat (6) @(negedge clk_ram);
        check("nodl_no_write", log_we.size(), s);

        // Address jump: partial word flushed, new byte held, then flushed at session end
        tick();
        ioctl_download = 1'b1;
        tick();
        ioctl_byte(25'h010, 8'h11);
        ioctl_byte(25'h021, 8'h22);
        wait_ack("jump");
        check("jump_addr", mem_addr, 32'h8);
        check("jump_be", mem_be, 32'h1);
        check("jump_wdata", mem_wdata, 32'h0011);
        @(negedge clk_ram);
        check("jump_wait_low", ioctl_wait, 32'd0);
        tick();
        ioctl_download = 1'b0;
        wait_ack("hold");
        check("hold_addr", mem_addr, 32'h10);
        check("hold_be", mem_be, 32'h2);
        check("hold_wdata_hi", mem_wdata[15:8], 32'h22);

        // Video read
        tick();
        vid_addr = 24'h000100;
        vid_req  = 1'b1;
        tick();
        @(negedge clk_ram);
        check("rd_req", {mem_req, mem_we}, 32'h2);
        check("rd_addr", mem_addr, 32'h100);
        wait_ack("rd");
        check("rd_vid_ack", vid_ack, 32'd1);
        tick();
        vid_req = 1'b0;
        n = 0;
        do begin @(negedge clk_ram); n++; end while (!vid_valid && n < 20);
        check("rd_valid_latency", n, 32'd4);
        check("rd_data", vid_data, 32'hBEEF);
        @(negedge clk_ram);
        check("rd_valid_pulse", vid_valid, 32'd0);

        // Contention: word becomes ready in the same IDLE cycle that vid_req rises
        tick();
        ioctl_download = 1'b1;
        vid_addr = 24'h000200;
        base = log_we.size();
        ioctl_byte(25'h200, 8'h55);
        ioctl_addr = 25'h201; ioctl_dout = 8'h66; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        vid_req  = 1'b1;
`ifdef BOCKS_ARB_STARVE_EN
        n = 0;
        while (log_we.size() < base + 5 && n < 300) begin @(negedge clk_ram); n++; end
        check("starve_seen", log_we.size() >= base + 5, 32'd1);
        pat = {log_we[base+4], log_we[base+3], log_we[base+2], log_we[base+1], log_we[base]};
        check("starve_order", pat, 32'b10000);
        check("starve_waddr", log_addr[base+4], 32'h100);
        check("starve_wdata", log_wdata[base+4], 32'h6655);
        check("starve_wbe", log_be[base+4], 32'h3);
        wait_ack("starve_tail");
        tick();
        vid_req = 1'b0;
        repeat (10) @(negedge clk_ram);
`else
        repeat (60) @(negedge clk_ram);
        nw = 0;
        for (int i = base; i < log_we.size(); i++) nw += int'(log_we[i]);
        check("strict_no_write", nw, 32'd0);
        check("strict_reads", (log_we.size() - base) >= 5, 32'd1);
        wait_ack("strict_last_rd");
        tick();
        vid_req = 1'b0;
        s = log_we.size();
        n = 0;
        while (log_we.size() < s + 1 && n < 100) begin @(negedge clk_ram); n++; end
        check("strict_write_next", log_we[s], 32'd1);
        check("strict_waddr", log_addr[s], 32'h100);
        check("strict_wdata", log_wdata[s], 32'h6655);
        check("strict_wbe", log_be[s], 32'h3);
        repeat (4) @(negedge clk_ram);
`endif

        // Reset in VID_WAIT with a download word still pending
        tick();
        ioctl_byte(25'h300, 8'h77);
        ioctl_addr = 25'h301; ioctl_dout = 8'h88; ioctl_wr = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        vid_addr = 24'h000123;
        vid_req  = 1'b1;
        wait_ack("rst_rd");
        check("rst_rd_is_vid", vid_ack, 32'd1);
        tick();
        vid_req = 1'b0;
        @(negedge clk_ram);
        check("rst_pre_wait", ioctl_wait, 32'd1);
        s = log_we.size();
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_a", {ioctl_wait, vid_ack, vid_valid, mem_req, mem_we, mem_be}, 32'd0);
        check("rst_async_vid_data", vid_data, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        spurious = 0;
        repeat (10) begin
            @(negedge clk_ram);
            if (vid_valid || mem_req) spurious++;
        end
        check("rst_no_spurious", spurious, 32'd0);
        check("rst_post_wait", ioctl_wait, 32'd0);
        check("rst_no_write", log_we.size(), s);
        tick();
        vid_addr = 24'h000042;
        vid_req  = 1'b1;
        tick();
        @(negedge clk_ram);
        check("rst_idle_req", mem_req, 32'd1);
        check("rst_idle_addr", mem_addr, 32'h42);
        wait_ack("rst_post_rd");
        tick();
        vid_req = 1'b0;
        n = 0;
        do begin @(negedge clk_ram); n++; end while (!vid_valid && n < 20);
        check("rst_post_rd_data", {15'b0, vid_valid, vid_data}, 32'h1BEEF);
        ioctl_download = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
